// File: rtl/fetch_unit_if.sv
// Fetch unit bus: control from the pipeline, instruction memory port and decode handshake.
// The master modport is the fetch unit side; slave is memory plus decode.
interface fetch_unit_if;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  logic          halt;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;
  logic [DW-1:0] ir;
  logic [AW-1:0] ir_pc;
  logic          ir_valid;
  logic          ir_ready;
  logic [CW-1:0] count;

  modport master (
    input  halt, redirect, redirect_pc, imem_data, ir_ready,
    output imem_req, imem_addr, ir, ir_pc, ir_valid, count
  );

  modport slave (
    output halt, redirect, redirect_pc, imem_data, ir_ready,
    input  imem_req, imem_addr, ir, ir_pc, ir_valid, count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited sequential fetch into a circular queue,
// with redirect flush, halt freeze and one-cycle memory read latency.
module fetch_unit #(
  parameter int unsigned DEPTH   = 4,
  parameter logic [15:0] RESETPC = 16'h0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 16;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] ins;
  } entry_t;

  entry_t           q_mem [DEPTH];
  entry_t           wr_entry;
  entry_t           head_entry;

  logic [AW-1:0]    fpc_q, fpc_d;
  logic [AW-1:0]    inf_pc_q, inf_pc_d;
  logic             inf_q, inf_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             req_c;
  logic             enq_c;
  logic             deq_c;

  // Credit rule: queued plus in-flight words never exceed DEPTH, so an arriving word always fits.
  always_comb begin
    req_c = !reset && !bus.redirect && !bus.halt &&
            ((count_q + CNT_W'(inf_q)) < CNT_W'(DEPTH));
    enq_c = inf_q && !bus.redirect && !reset;
    deq_c = (count_q != '0) && bus.ir_ready;
  end

  always_comb begin
    fpc_d    = fpc_q;
    inf_d    = inf_q;
    inf_pc_d = inf_pc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    if (bus.redirect) begin
      // Flush wins over any concurrent dequeue; the returning word is dropped.
      fpc_d   = bus.redirect_pc;
      inf_d   = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      inf_d = req_c;
      if (req_c) begin
        fpc_d    = fpc_q + 16'd1;
        inf_pc_d = fpc_q;
      end
      if (enq_c) tail_d = tail_q + PTR_W'(1);
      if (deq_c) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(enq_c) - CNT_W'(deq_c);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q    <= RESETPC;
      inf_q    <= 1'b0;
      inf_pc_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else begin
      fpc_q    <= fpc_d;
      inf_q    <= inf_d;
      inf_pc_q <= inf_pc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    wr_entry.pc  = inf_pc_q;
    wr_entry.ins = bus.imem_data;
  end

  // Queue storage needs no reset: outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (enq_c) q_mem[tail_q] <= wr_entry;
  end

  assign head_entry    = q_mem[head_q];
  assign bus.imem_req  = req_c;
  assign bus.imem_addr = fpc_q;
  assign bus.ir_valid  = (count_q != '0);
  assign bus.ir        = (count_q != '0) ? head_entry.ins : '0;
  assign bus.ir_pc     = (count_q != '0) ? head_entry.pc  : '0;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory returns 16'h1000 + addr one cycle after each request.
module tb_fetch_unit;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  fetch_unit_if bus();

  fetch_unit #(.DEPTH(4), .RESETPC(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: junk value on cycles with no request so stray captures show up.
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_data <= 16'(16'h1000 + bus.imem_addr);
    else              bus.imem_data <= 16'hBAD0;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset(input logic rdy);
    reset           = 1'b1;
    bus.halt        = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.ir_ready    = rdy;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    bus.halt        = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.ir_ready    = 1'b1;
    tick();
    tick();
    #1;
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
    n_checks++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.ir_valid); end
    n_checks++; if (bus.ir !== 16'h0000) begin n_fail++; $display("FAIL reset_ir: got %h expected 0000", bus.ir); end
    n_checks++; if (bus.ir_pc !== 16'h0000) begin n_fail++; $display("FAIL reset_irpc: got %h expected 0000", bus.ir_pc); end
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
  endtask

  task automatic test_startup();
    apply_reset(1'b1);
    n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL start_req: got %b expected 1", bus.imem_req); end
    n_checks++; if (bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL start_addr: got %h expected 0000", bus.imem_addr); end
    tick();
    n_checks++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL start_valid1: got %b expected 0", bus.ir_valid); end
    n_checks++; if (bus.imem_addr !== 16'h0001) begin n_fail++; $display("FAIL start_addr1: got %h expected 0001", bus.imem_addr); end
    tick();
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (bus.ir_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b expected 1", k, bus.ir_valid); end
      n_checks++; if (bus.ir_pc !== 16'(k)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h expected %h", k, bus.ir_pc, 16'(k)); end
      n_checks++; if (bus.ir !== 16'(16'h1000 + k)) begin n_fail++; $display("FAIL stream_ir[%0d]: got %h expected %h", k, bus.ir, 16'(16'h1000 + k)); end
      n_checks++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d expected 1", k, bus.count); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    apply_reset(1'b0);
    repeat (4) tick();
    n_checks++; if (bus.count !== 4'd3) begin n_fail++; $display("FAIL bp_count3: got %0d expected 3", bus.count); end
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_credit_req: got %b expected 0", bus.imem_req); end
    repeat (6) tick();
    n_checks++; if (bus.count !== 4'd4) begin n_fail++; $display("FAIL bp_count4: got %0d expected 4", bus.count); end
    n_checks++; if (bus.ir_pc !== 16'h0000) begin n_fail++; $display("FAIL bp_head: got %h expected 0000", bus.ir_pc); end
    bus.ir_ready = 1'b1;
    #1;
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_full_req: got %b expected 0", bus.imem_req); end
    for (int k = 0; k < 7; k++) begin
      n_checks++; if (bus.ir_pc !== 16'(k)) begin n_fail++; $display("FAIL bp_pc[%0d]: got %h expected %h", k, bus.ir_pc, 16'(k)); end
      n_checks++; if (bus.ir !== 16'(16'h1000 + k)) begin n_fail++; $display("FAIL bp_ir[%0d]: got %h expected %h", k, bus.ir, 16'(16'h1000 + k)); end
      tick();
    end
  endtask

  task automatic test_redirect();
    apply_reset(1'b0);
    repeat (4) tick();
    n_checks++; if (bus.count !== 4'd3) begin n_fail++; $display("FAIL rd_pre_count: got %0d expected 3", bus.count); end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0040;
    #1;
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rd_req_during: got %b expected 0", bus.imem_req); end
    tick();
    bus.redirect = 1'b0;
    #1;
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL rd_count: got %0d expected 0", bus.count); end
    n_checks++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid: got %b expected 0", bus.ir_valid); end
    n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rd_req: got %b expected 1", bus.imem_req); end
    n_checks++; if (bus.imem_addr !== 16'h0040) begin n_fail++; $display("FAIL rd_addr: got %h expected 0040", bus.imem_addr); end
    tick();
    n_checks++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid1: got %b expected 0", bus.ir_valid); end
    tick();
    n_checks++; if (bus.ir_pc !== 16'h0040) begin n_fail++; $display("FAIL rd_irpc: got %h expected 0040", bus.ir_pc); end
    n_checks++; if (bus.ir !== 16'h1040) begin n_fail++; $display("FAIL rd_ir: got %h expected 1040", bus.ir); end
    n_checks++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL rd_count1: got %0d expected 1", bus.count); end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_pc [4];
    logic [15:0] exp_ir [4];
    exp_pc = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    exp_ir = '{16'h0FFE, 16'h0FFF, 16'h1000, 16'h1001};
    apply_reset(1'b1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    tick();
    bus.redirect = 1'b0;
    #1;
    n_checks++; if (bus.imem_addr !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_addr: got %h expected fffe", bus.imem_addr); end
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (bus.ir_pc !== exp_pc[k]) begin n_fail++; $display("FAIL wrap_pc[%0d]: got %h expected %h", k, bus.ir_pc, exp_pc[k]); end
      n_checks++; if (bus.ir !== exp_ir[k]) begin n_fail++; $display("FAIL wrap_ir[%0d]: got %h expected %h", k, bus.ir, exp_ir[k]); end
      tick();
    end
  endtask

  task automatic test_halt();
    apply_reset(1'b0);
    tick();
    bus.halt = 1'b1;
    #1;
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_req: got %b expected 0", bus.imem_req); end
    tick();
    n_checks++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL halt_land: got %0d expected 1", bus.count); end
    n_checks++; if (bus.ir !== 16'h1000) begin n_fail++; $display("FAIL halt_ir: got %h expected 1000", bus.ir); end
    tick();
    tick();
    n_checks++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL halt_hold: got %0d expected 1", bus.count); end
    bus.halt = 1'b0;
    #1;
    n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL halt_resume_req: got %b expected 1", bus.imem_req); end
    n_checks++; if (bus.imem_addr !== 16'h0001) begin n_fail++; $display("FAIL halt_resume_addr: got %h expected 0001", bus.imem_addr); end
    tick();
    tick();
    n_checks++; if (bus.count !== 4'd2) begin n_fail++; $display("FAIL halt_resume_count: got %0d expected 2", bus.count); end
  endtask

  task automatic test_redirect_halt();
    apply_reset(1'b1);
    repeat (3) tick();
    bus.halt        = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0100;
    tick();
    bus.redirect = 1'b0;
    #1;
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL rh_count: got %0d expected 0", bus.count); end
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rh_req: got %b expected 0", bus.imem_req); end
    n_checks++; if (bus.imem_addr !== 16'h0100) begin n_fail++; $display("FAIL rh_addr: got %h expected 0100", bus.imem_addr); end
    tick();
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL rh_count1: got %0d expected 0", bus.count); end
    bus.halt = 1'b0;
    #1;
    n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rh_resume: got %b expected 1", bus.imem_req); end
  endtask

  task automatic test_reset_mid();
    apply_reset(1'b0);
    repeat (4) tick();
    reset = 1'b1;
    #1;
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rm_req: got %b expected 0", bus.imem_req); end
    tick();
    reset = 1'b0;
    #1;
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL rm_count: got %0d expected 0", bus.count); end
    n_checks++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b expected 0", bus.ir_valid); end
    n_checks++; if (bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL rm_addr: got %h expected 0000", bus.imem_addr); end
    tick();
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL rm_stale: got %0d expected 0", bus.count); end
    tick();
    n_checks++; if (bus.ir_pc !== 16'h0000) begin n_fail++; $display("FAIL rm_irpc: got %h expected 0000", bus.ir_pc); end
    n_checks++; if (bus.ir !== 16'h1000) begin n_fail++; $display("FAIL rm_ir: got %h expected 1000", bus.ir); end
    n_checks++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL rm_count1: got %0d expected 1", bus.count); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_startup();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_redirect_halt();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
